// File: rtl/itof_if.sv
// itof_converter handshake bundle: request side (valid/op/rm/int)
// and result side (valid/float/IE) with downstream ready.
interface itof_if;
    logic        valid_in;
    logic        ready_out;
    logic [4:0]  op;
    logic [2:0]  rm;
    logic [31:0] int_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] float_out;
    logic        IE;

    modport master (
        output valid_in, op, rm, int_in, ready_in,
        input  ready_out, valid_out, float_out, IE
    );

    modport slave (
        input  valid_in, op, rm, int_in, ready_in,
        output ready_out, valid_out, float_out, IE
    );
endinterface

// File: rtl/itof_converter.sv
// int32/uint32 -> binary32 converter: normalize stage, then round/pack.
// Define ITOF_SINGLE_CYCLE_EN to fold both stages into one cycle.
module itof_converter (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    itof_if.slave  bus
);
    localparam logic [4:0] FPU_OP_CVTIF = 5'd8;
    localparam logic [4:0] FPU_OP_CVTUF = 5'd9;
    localparam logic [2:0] FPU_RM_RNE   = 3'd0;
    localparam logic [2:0] FPU_RM_RTZ   = 3'd1;
    localparam logic [2:0] FPU_RM_RDN   = 3'd2;
    localparam logic [2:0] FPU_RM_RUP   = 3'd3;
    localparam logic [2:0] FPU_RM_RMM   = 3'd4;

    logic        op_ok;
    logic        accept;
    logic        s2_free;
    logic        s2_load;
    logic        s2_valid_q;
    logic [31:0] s2_res_q, s2_res_d;
    logic        s2_ie_q, s2_ie_d;

    // stage 1 combinational: sign/magnitude, leading zeros, normalize
    logic        sgn1;
    logic [31:0] mag1;
    logic [4:0]  lz1;
    logic [31:0] norm1;
    logic [7:0]  exp1;

    always_comb begin
        sgn1 = (bus.op == FPU_OP_CVTIF) && bus.int_in[31];
        mag1 = sgn1 ? (~bus.int_in + 32'd1) : bus.int_in;
        lz1  = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (mag1[i]) lz1 = 5'(31 - i);
        end
        norm1 = mag1 << lz1;
        exp1  = 8'd158 - {3'b000, lz1};
    end

    assign op_ok   = (bus.op == FPU_OP_CVTIF) || (bus.op == FPU_OP_CVTUF);
    assign s2_free = !s2_valid_q || bus.ready_in;
    assign accept  = bus.valid_in && bus.ready_out && !flush;

    logic [23:0] a_man;
    logic        a_rnd, a_stk, a_sgn, a_zero;
    logic [7:0]  a_exp;
    logic [2:0]  a_rm;

`ifdef ITOF_SINGLE_CYCLE_EN
    assign bus.ready_out = s2_free && op_ok;
    assign s2_load       = accept;

    always_comb begin
        a_man  = norm1[31:8];
        a_rnd  = norm1[7];
        a_stk  = |norm1[6:0];
        a_exp  = exp1;
        a_sgn  = sgn1;
        a_zero = (mag1 == 32'd0);
        a_rm   = bus.rm;
    end
`else
    logic        s1_valid_q;
    logic [23:0] s1_man_q;
    logic        s1_rnd_q, s1_stk_q, s1_sgn_q, s1_zero_q;
    logic [7:0]  s1_exp_q;
    logic [2:0]  s1_rm_q;
    logic        s1_adv;

    assign s1_adv        = s1_valid_q && s2_free;
    assign bus.ready_out = (!s1_valid_q || s1_adv) && op_ok;
    assign s2_load       = s1_adv;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            s1_valid_q <= 1'b0;
            s1_man_q   <= '0;
            s1_rnd_q   <= 1'b0;
            s1_stk_q   <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_rm_q    <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_man_q   <= norm1[31:8];
            s1_rnd_q   <= norm1[7];
            s1_stk_q   <= |norm1[6:0];
            s1_sgn_q   <= sgn1;
            s1_zero_q  <= (mag1 == 32'd0);
            s1_exp_q   <= exp1;
            s1_rm_q    <= bus.rm;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_comb begin
        a_man  = s1_man_q;
        a_rnd  = s1_rnd_q;
        a_stk  = s1_stk_q;
        a_exp  = s1_exp_q;
        a_sgn  = s1_sgn_q;
        a_zero = s1_zero_q;
        a_rm   = s1_rm_q;
    end
`endif

    // stage 2: rounding increment, carry into exponent, pack
    logic        inc;
    logic [24:0] sum2;
    logic [7:0]  exp2;
    logic [22:0] frac2;

    always_comb begin
        unique case (1'b1)
            a_rm == FPU_RM_RTZ: inc = 1'b0;
            a_rm == FPU_RM_RDN: inc = a_sgn && (a_rnd || a_stk);
            a_rm == FPU_RM_RUP: inc = !a_sgn && (a_rnd || a_stk);
            a_rm == FPU_RM_RMM: inc = a_rnd;
            default:            inc = a_rnd && (a_stk || a_man[0]);
        endcase
        sum2  = {1'b0, a_man} + {24'd0, inc};
        exp2  = a_exp + {7'd0, sum2[24]};
        frac2 = 23'(sum2[23:0]);
        s2_res_d = a_zero ? 32'd0 : {a_sgn, exp2, frac2};
        s2_ie_d  = a_rnd || a_stk;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_ie_q    <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            s2_res_q   <= s2_res_d;
            s2_ie_q    <= s2_ie_d;
        end else if (bus.ready_in) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign bus.valid_out = s2_valid_q && !flush;
    assign bus.float_out = s2_res_q;
    assign bus.IE        = s2_ie_q;

    logic unused_rm;
    assign unused_rm = (FPU_RM_RNE != 3'd0);
endmodule

// File: tb/tb_itof_converter.sv
// Bench for itof_converter: directed table, pipeline corner cases,
// and randomized ops against an arithmetic rounding model.
module tb_itof_converter;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_IF  = 5'd8;
    localparam logic [4:0] OP_UF  = 5'd9;
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3, RMM = 3'd4;
`ifdef ITOF_SINGLE_CYCLE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset, flush;
    itof_if bus();

    itof_converter dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rm;
        logic [31:0] x;
        logic [31:0] f;
        logic        ie;
    } vec_t;

    typedef struct {
        logic [31:0] f;
        logic        ie;
    } res_t;

    vec_t tv[16];
    res_t expq[$];
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] cur_f;
    logic        cur_ie;
    bit          held = 0;
    logic [31:0] held_f;
    logic        held_ie;
    bit          mon_on = 0;
    bit          rnd_done = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic void model(input logic [4:0] op, input logic [2:0] rm,
                                  input logic [31:0] x,
                                  output logic [31:0] f, output logic ie);
        logic s, up;
        longint m, q, rem, half;
        int e, sh;
        logic [2:0] r;
        s = (op == OP_IF) && x[31];
        m = longint'({32'd0, x});
        if (s) m = (longint'(1) << 32) - m;
        if (m == 0) begin
            f = 32'd0;
            ie = 1'b0;
            return;
        end
        e = 31;
        while (m < (longint'(1) << e)) e--;
        if (e <= 23) begin
            q = m << (23 - e);
            rem = 0;
            half = 1;
        end else begin
            sh = e - 23;
            q = m >> sh;
            rem = m - (q << sh);
            half = longint'(1) << (sh - 1);
        end
        r = (rm > RMM) ? RNE : rm;
        case (r)
            RTZ: up = 1'b0;
            RDN: up = s && (rem != 0);
            RUP: up = !s && (rem != 0);
            RMM: up = (rem >= half);
            default: up = (rem > half) || ((rem == half) && q[0]);
        endcase
        q = q + longint'(up);
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        f = {s, 8'(e + 127), q[22:0]};
        ie = (rem != 0);
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (reset || flush) begin
                expq.delete();
                held = 0;
            end else begin
                if (held) begin
                    check("hold_valid", 32'(bus.valid_out), 32'd1);
                    check("hold_float", bus.float_out, held_f);
                    check("hold_ie", 32'(bus.IE), 32'(held_ie));
                end
                if (bus.valid_out && bus.ready_in) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_result: got %h want none",
                                 bus.float_out);
                    end else begin
                        res_t r;
                        r = expq.pop_front();
                        check("result_float", bus.float_out, r.f);
                        check("result_ie", 32'(bus.IE), 32'(r.ie));
                    end
                end
                if (bus.valid_in && bus.ready_out)
                    expq.push_back('{cur_f, cur_ie});
                held = bus.valid_out && !bus.ready_in;
                held_f = bus.float_out;
                held_ie = bus.IE;
            end
        end
    end

    task automatic send(logic [4:0] op, logic [2:0] rm, logic [31:0] x,
                        logic [31:0] f, logic ie);
        int b = 0;
        bus.op = op;
        bus.rm = rm;
        bus.int_in = x;
        cur_f = f;
        cur_ie = ie;
        bus.valid_in = 1'b1;
        do begin
            @(negedge clk);
            b++;
        end while (!bus.ready_out && b < 200);
        if (!bus.ready_out) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got ready 0 want 1");
        end
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
    endtask

    task automatic send_model(logic [4:0] op, logic [2:0] rm, logic [31:0] x);
        logic [31:0] f;
        logic ie;
        model(op, rm, x, f, ie);
        send(op, rm, x, f, ie);
    endtask

    task automatic latency_check(logic [31:0] x);
        send_model(OP_IF, RNE, x);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("latency", 32'(bus.valid_out), 32'(k == LAT));
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{OP_IF, RNE, 32'h00000001, 32'h3F800000, 1'b0};
        tv[1]  = '{OP_IF, RNE, 32'hFFFFFFFF, 32'hBF800000, 1'b0};
        tv[2]  = '{OP_UF, RNE, 32'h00000000, 32'h00000000, 1'b0};
        tv[3]  = '{OP_IF, RNE, 32'h80000000, 32'hCF000000, 1'b0};
        tv[4]  = '{OP_IF, RDN, 32'h80000000, 32'hCF000000, 1'b0};
        tv[5]  = '{OP_IF, RUP, 32'h80000000, 32'hCF000000, 1'b0};
        tv[6]  = '{OP_UF, RNE, 32'h80000000, 32'h4F000000, 1'b0};
        tv[7]  = '{OP_UF, RNE, 32'hFFFFFFFF, 32'h4F800000, 1'b1};
        tv[8]  = '{OP_UF, RTZ, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b1};
        tv[9]  = '{OP_UF, RUP, 32'hFFFFFFFF, 32'h4F800000, 1'b1};
        tv[10] = '{OP_IF, RNE, 32'h01000001, 32'h4B800000, 1'b1};
        tv[11] = '{OP_IF, RUP, 32'h01000001, 32'h4B800001, 1'b1};
        tv[12] = '{OP_IF, RMM, 32'h01000001, 32'h4B800001, 1'b1};
        tv[13] = '{OP_IF, RDN, 32'hFEFFFFFF, 32'hCB800001, 1'b1};
        tv[14] = '{OP_IF, RUP, 32'hFEFFFFFF, 32'hCB800000, 1'b1};
        tv[15] = '{OP_IF, 3'd7, 32'h01000003, 32'h4B800002, 1'b1};

        reset = 1'b1;
        flush = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        bus.op = OP_IF;
        bus.rm = RNE;
        bus.int_in = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(bus.valid_out), 32'd0);
        check("reset_float", bus.float_out, 32'd0);
        check("reset_ie", 32'(bus.IE), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1;

        for (int i = 0; i < 16; i++)
            send(tv[i].op, tv[i].rm, tv[i].x, tv[i].f, tv[i].ie);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        latency_check(32'd5);

        // backpressure: A, B, C with ready_in low
        bus.ready_in = 1'b0;
        fork
            begin
                send_model(OP_IF, RNE, 32'd7);
                send_model(OP_UF, RTZ, 32'h12345679);
                send_model(OP_IF, RDN, 32'hF0000001);
            end
            begin
                int b = 0;
                do begin
                    @(negedge clk);
                    b++;
                end while (!bus.valid_out && b < 50);
                check("bp_valid_seen", 32'(bus.valid_out), 32'd1);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_ready_low", 32'(bus.ready_out), 32'd0);
                end
                @(posedge clk);
                #1 bus.ready_in = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_no_bubble", 32'(bus.valid_out), 32'd1);
                end
            end
        join
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // flush with two ops in flight and a new op offered
        send_model(OP_IF, RNE, 32'd100);
        send_model(OP_IF, RNE, 32'd200);
        flush = 1'b1;
        bus.op = OP_IF;
        bus.int_in = 32'd300;
        bus.valid_in = 1'b1;
        @(negedge clk);
        check("flush_valid", 32'(bus.valid_out), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        bus.valid_in = 1'b0;
        repeat (LAT + 1) begin
            @(negedge clk);
            check("post_flush_idle", 32'(bus.valid_out), 32'd0);
        end
        @(posedge clk);
        #1;
        latency_check(32'd9);

        // reset mid-stream
        send_model(OP_UF, RNE, 32'd11);
        send_model(OP_UF, RNE, 32'd12);
        reset = 1'b1;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.valid_in = 1'b0;
        repeat (LAT + 1) begin
            @(negedge clk);
            check("post_reset_idle", 32'(bus.valid_out), 32'd0);
        end
        check("post_reset_float", bus.float_out, 32'd0);
        check("post_reset_ie", 32'(bus.IE), 32'd0);
        @(posedge clk);
        #1;
        latency_check(32'hFFFFFF00);

        // unsupported op is never accepted
        bus.op = OP_ADD;
        bus.valid_in = 1'b1;
        @(negedge clk);
        check("badop_ready", 32'(bus.ready_out), 32'd0);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        bus.op = OP_IF;
        repeat (3) begin
            @(negedge clk);
            check("badop_idle", 32'(bus.valid_out), 32'd0);
        end
        @(posedge clk);
        #1;

        // randomized ops with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] x;
                    logic [4:0] op;
                    logic [2:0] rm;
                    op = ($urandom_range(0, 1) != 0) ? OP_IF : OP_UF;
                    rm = 3'($urandom_range(0, 7));
                    case ($urandom_range(0, 3))
                        0: x = $urandom;
                        1: x = $urandom >> $urandom_range(0, 31);
                        2: x = (32'd1 << $urandom_range(0, 31)) |
                               32'($urandom_range(0, 3));
                        default: x = -32'($urandom_range(0, 300));
                    endcase
                    send_model(op, rm, x);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.ready_in = ($urandom_range(0, 3) != 0);
                end
                bus.ready_in = 1'b1;
            end
        join
        begin
            int b = 0;
            while (expq.size() != 0 && b < 100) begin
                @(negedge clk);
                b++;
            end
        end
        check("drain_empty", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
